serial_word_loader: RTL and testbench

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

---
 rtl/serial_word_loader.sv | 147 ++++++++++++++
 tb/tb_serial_word_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
//
// Assembles a WIDTH-bit word from a serial bit stream (MSB first) and presents
// it to a downstream enable register. While the word is held, en stays high
// so the downstream register keeps loading (it clears whenever en is low).
//
// Handshake: sin is taken on a rising edge only when sin_valid=1 while the
// block is in SHIFT. There is no backpressure; the producer may leave gaps of
// any length by holding sin_valid=0. Control priority is abort > start >
// sin_valid.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-low reset
//   start      in   begin (or restart) assembling a word
//   abort      in   cancel and return to IDLE, d untouched
//   sin        in   serial data bit, MSB first
//   sin_valid  in   qualifies sin
//   d          out  last completed word (downstream register data)
//   en         out  downstream register enable, high for all of HOLD
//   busy       out  high while in SHIFT
//   done       out  one-cycle pulse in the first cycle of HOLD
//   bit_cnt    out  bits accepted so far for the current word
//   state_dbg  out  raw FSM state encoding for observation
// -----------------------------------------------------------------------------
module serial_word_loader #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] d,
   output logic             en,
   output logic             busy,
   output logic             done,
   output logic [4:0]       bit_cnt,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sr;
   logic [4:0]       cnt;
   logic [WIDTH-1:0] d_r;
   logic             done_r;

   // A bit is accepted only in SHIFT and only when neither control input
   // overrides it; a start on the same edge discards that bit.
   logic take_bit;
   logic last_bit;

   assign take_bit = (state == SHIFT) && !abort && !start && sin_valid;
   assign last_bit = take_bit && (cnt == CNT_LAST);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_nxt = IDLE;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = start ? SHIFT : IDLE;
            SHIFT: begin
               if (start) begin
                  state_nxt = SHIFT;
               end else if (last_bit) begin
                  state_nxt = HOLD;
               end else begin
                  state_nxt = SHIFT;
               end
            end
            HOLD:    state_nxt = start ? SHIFT : HOLD;
            // The spare encoding recovers to IDLE on the next edge.
            default: state_nxt = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      en   = 1'b0;
      busy = 1'b0;
      case (state)
         SHIFT:   busy = 1'b1;
         HOLD:    en   = 1'b1;
         default: begin
            en   = 1'b0;
            busy = 1'b0;
         end
      endcase
   end

   assign d         = d_r;
   assign done      = done_r;
   assign bit_cnt   = cnt;
   assign state_dbg = state;

   // ----------------------------------------------------------------- datapath
   // d_r is written only on the completing edge, so abort and restart never
   // disturb the word the downstream register is holding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr     <= '0;
         cnt    <= '0;
         d_r    <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (last_bit) begin
            d_r    <= {sr[WIDTH-2:0], sin};
            done_r <= 1'b1;
            sr     <= '0;
            cnt    <= '0;
         end else if (take_bit) begin
            sr  <= {sr[WIDTH-2:0], sin};
            cnt <= cnt + 5'd1;
         end else if (abort || start || (state != SHIFT)) begin
            // Any abort, any (re)start and every non-SHIFT state leave the
            // partial word empty.
            sr  <= '0;
            cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_word_loader
//
// Bench for serial_word_loader (WIDTH=16). Inputs are driven 1 time unit after
// each rising edge and outputs are compared 1 time unit after the next one.
// A downstream enable register (clears when en is low) is modelled here so
// the held value q can be observed.
// -----------------------------------------------------------------------------
module tb_serial_word_loader;

  localparam int W = 16;

  // ------------------------------------------------------- clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort, sin, sin_valid;
  logic [W-1:0] d;
  logic         en, busy, done;
  logic [4:0]   bit_cnt;
  logic [1:0]   state_dbg;
  logic [W-1:0] q;

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .sin       (sin),
    .sin_valid (sin_valid),
    .d         (d),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .bit_cnt   (bit_cnt),
    .state_dbg (state_dbg)
  );

  // Downstream register: loads d while en is high, clears when en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= en ? d : '0;
  end

  // ------------------------------------------------------- counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Word in progress is a queue of accepted bits; mode 0=idle 1=collect 2=hold.
  int           m_mode;
  logic [W-1:0] m_d;
  logic         m_done;
  bit           m_bits[$];

  task automatic model_reset();
    m_mode = 0;
    m_d    = '0;
    m_done = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_step(input logic s, input logic a, input logic b, input logic v);
    m_done = 1'b0;
    if (a) begin
      m_mode = 0;
      m_bits.delete();
    end else if (m_mode == 0) begin
      if (s) begin
        m_mode = 1;
        m_bits.delete();
      end
    end else if (m_mode == 1) begin
      if (s) begin
        m_bits.delete();
      end else if (v) begin
        m_bits.push_back(b);
        if (m_bits.size() == W) begin
          m_d = '0;
          for (int i = 0; i < W; i++) m_d[W-1-i] = m_bits[i];
          m_mode = 2;
          m_done = 1'b1;
          m_bits.delete();
        end
      end
    end else begin
      if (s) begin
        m_mode = 1;
        m_bits.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".d"},       32'(d),       32'(m_d));
    chk({tag, ".en"},      32'(en),      32'(m_mode == 2));
    chk({tag, ".busy"},    32'(busy),    32'(m_mode == 1));
    chk({tag, ".done"},    32'(done),    32'(m_done));
    chk({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(m_bits.size()));
    chk({tag, ".done_busy"}, 32'(done && busy), 32'd0);
  endtask

  // ------------------------------------------------------- driver tasks
  task automatic cycle(input logic s, input logic a, input logic b, input logic v);
    start     = s;
    abort     = a;
    sin       = b;
    sin_valid = v;
    model_step(s, a, b, v);
    @(posedge clk);
    #1;
  endtask

  // Sends a full word MSB first with `gap` invalid cycles between bits.
  task automatic send_word(input logic [W-1:0] w, input int gap, input string tag);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1'b0, 1'b0, w[i], 1'b1);
      check_model(tag);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
          check_model(tag);
          chk({tag, ".cnt_max"}, 32'(bit_cnt <= 5'd15), 32'd1);
        end
      end
    end
    chk({tag, ".d_final"},  32'(d),    32'(w));
    chk({tag, ".en_final"}, 32'(en),   32'd1);
    chk({tag, ".done_fin"}, 32'(done), 32'd1);
    chk({tag, ".busy_fin"}, 32'(busy), 32'd0);
  endtask

  task automatic send_random_bits(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      check_model(tag);
    end
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset_mid(input string tag);
    start = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk({tag, ".d"},       32'(d),       32'd0);
    chk({tag, ".en"},      32'(en),      32'd0);
    chk({tag, ".busy"},    32'(busy),    32'd0);
    chk({tag, ".done"},    32'(done),    32'd0);
    chk({tag, ".bit_cnt"}, 32'(bit_cnt), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ------------------------------------------------------- vector table
  typedef struct packed {
    logic       s, a, b, v;
    logic       en, busy, done;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl[11];

  // ------------------------------------------------------- main sequence
  logic saw_done;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.q", 32'(q), 32'd0);
    rst = 1'b1;

    //           s    a    b    v    en   busy done cnt
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0};
    tbl[1]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,5'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd1};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'd1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,5'd2};
    tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd0};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,5'd1};
    tbl[8]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,5'd0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5'd0};

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].v);
      chk($sformatf("tbl%0d.en", i),      32'(en),      32'(tbl[i].en));
      chk($sformatf("tbl%0d.busy", i),    32'(busy),    32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i),    32'(done),    32'(tbl[i].done));
      chk($sformatf("tbl%0d.bit_cnt", i), 32'(bit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d.d", i),       32'(d),       32'd0);
    end

    // Basic word 0xA5C3 with no gaps.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(16'hA5C3, 0, "basic");
    chk("basic.q_pre", 32'(q), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("basic.done_off", 32'(done), 32'd0);
    chk("basic.en_hold",  32'(en),   32'd1);
    chk("basic.q",        32'(q),    32'hA5C3);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    chk("basic.q_held",   32'(q),    32'hA5C3);
    chk("basic.d_held",   32'(d),    32'hA5C3);

    // Abort after 7 bits: d keeps the previous word, no done pulse.
    saw_done = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort.en_drop", 32'(en), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      check_model("abort");
      saw_done |= done;
    end
    chk("abort.cnt7", 32'(bit_cnt), 32'd7);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    saw_done |= done;
    check_model("abort");
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.en",   32'(en),   32'd0);
    chk("abort.d",    32'(d),    32'hA5C3);
    chk("abort.no_done", 32'(saw_done), 32'd0);

    // Gaps of 3 idle cycles between bits.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(16'h00FF, 3, "gaps");

    // Restart in SHIFT after 5 bits; the bit on the restart edge is dropped.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_random_bits(5, "restart");
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    chk("restart.cnt0", 32'(bit_cnt), 32'd0);
    send_word(16'h1234, 0, "restart");

    // Start in HOLD reloads: en drops, d keeps old word until completion.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reload.en",   32'(en),   32'd0);
    chk("reload.busy", 32'(busy), 32'd1);
    chk("reload.d",    32'(d),    32'h1234);
    send_word(16'hFFFF, 0, "reload");

    // start and abort together in HOLD: abort wins.
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_model("both");
    chk("both.en",   32'(en),   32'd0);
    chk("both.busy", 32'(busy), 32'd0);
    chk("both.d",    32'(d),    32'hFFFF);

    // Asynchronous reset at bit 10, then data without start is ignored.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_random_bits(10, "rst");
    async_reset_mid("rst_async");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1);
      chk("rst.no_start_cnt",  32'(bit_cnt), 32'd0);
      chk("rst.no_start_busy", 32'(busy),    32'd0);
    end
    check_model("rst_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset_mid("rand_rst");
      end else begin
        cycle(1'($urandom_range(0, 29) == 0),
              1'($urandom_range(0, 49) == 0),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) < 7));
        check_model("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
